// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule round constants,
// block/word types and the FIPS-197 S-box used by key expansion and SubBytes.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    // Entry r is the round constant consumed when producing RK_r; index 0 is unused.
    localparam logic [7:0] RCON [0:NR] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Byte 0x00 sits in the top byte, so entry b lives at bits [2047-8b -: 8].
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return SBOX_FLAT[base -: 8];
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One combinational AES-128 key-expansion step: next round key from the
// previous round key and that round's constant.
module aes_key_round
    import aes_pkg::*;
(
    input  aes_block_t  key_in,
    input  logic [7:0]  rcon,
    output aes_block_t  key_out
);

    aes_word_t w0, w1, w2, w3;
    aes_word_t rot_w3;
    aes_word_t t;
    aes_word_t n0, n1, n2, n3;

    always_comb begin
        w0 = key_in[127:96];
        w1 = key_in[95:64];
        w2 = key_in[63:32];
        w3 = key_in[31:0];

        rot_w3 = {w3[23:0], w3[31:24]};
        t = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
             sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])} ^ {rcon, 24'h0};

        // Each new word chains off the one just produced, not the old one.
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;

        key_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched.sv
// Fully pipelined AES-128 key schedule: stage r holds RK_r for the block that
// round stage r is processing, one key accepted per cycle, no stall.
module aes_key_sched
    import aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [127:0]            key_in,
    input  logic                    key_vld,
    output logic [128*(NR+1)-1:0]   rk_flat,
    output logic [NR:0]             rk_vld
);

    aes_block_t key_q [0:NR];
    aes_block_t key_d [0:NR];
    aes_block_t next_key [1:NR];
    logic [NR:0] vld_q;
    logic [NR:0] vld_d;

    for (genvar r = 1; r <= NR; r++) begin : g_round
        aes_key_round u_round (
            .key_in  (key_q[r-1]),
            .rcon    (RCON[r]),
            .key_out (next_key[r])
        );
    end

    // Key data moves regardless of valid; bubbles keep their slot.
    always_comb begin
        key_d[0] = key_in;
        for (int r = 1; r <= NR; r++) begin
            key_d[r] = next_key[r];
        end
        vld_d = {vld_q[NR-1:0], key_vld};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '{default: '0};
            vld_q <= '0;
        end else begin
            key_q <= key_d;
            vld_q <= vld_d;
        end
    end

    always_comb begin
        rk_flat = '0;
        for (int r = 0; r <= NR; r++) begin
            rk_flat[128*r +: 128] = key_q[r];
        end
        rk_vld = vld_q;
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 and zero-key vectors, bubbles,
// streaming against an independent key-expansion model, and reset behaviour.
module tb_aes_key_sched;

    localparam int NR = 10;

    logic                   clk;
    logic                   rst;
    logic [127:0]           key_in;
    logic                   key_vld;
    logic [128*(NR+1)-1:0]  rk_flat;
    logic [NR:0]            rk_vld;

    int n_checks;
    int n_errors;

    logic [7:0] ref_sbox [256];
    logic [127:0] exp_q[$];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_sched dut (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key_in),
        .key_vld (key_vld),
        .rk_flat (rk_flat),
        .rk_vld  (rk_vld)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %032h expected %032h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] stage_key(input int r);
        return rk_flat[128*r +: 128];
    endfunction

    function automatic logic [127:0] vld_word(input logic [NR:0] v);
        return {117'b0, v};
    endfunction

    // ---------------- reference model (S-box derived from GF(2^8)) ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_ref_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-indexed FIPS-197 expansion, returning round key n.
    function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int n);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {ref_sbox[temp[31:24]], ref_sbox[temp[23:16]],
                        ref_sbox[temp[15:8]],  ref_sbox[temp[7:0]]};
                temp = temp ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] k, input logic v);
        key_in  = k;
        key_vld = v;
    endtask

    task automatic idle(input int n);
        drive(128'h0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    // Push one key through alone and check every stage as it walks.
    task automatic single_key(input string name, input logic [127:0] k,
                              input logic [127:0] rk1, input logic [127:0] rk10);
        drive(k, 1'b1);
        step();
        drive(128'h0, 1'b0);
        for (int s = 0; s <= NR; s++) begin
            check_eq({name, "_vld"}, vld_word(rk_vld), vld_word(11'(1) << s));
            check_eq({name, "_model"}, stage_key(s), ref_round_key(k, s));
            if (s == 0)  check_eq({name, "_rk0"}, stage_key(0), k);
            if (s == 1)  check_eq({name, "_rk1"}, stage_key(1), rk1);
            if (s == NR) check_eq({name, "_rk10"}, stage_key(NR), rk10);
            if (s < NR) step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] k;
        n_checks = 0;
        n_errors = 0;
        build_ref_sbox();
        check_eq("model_fips_rk1",  ref_round_key(FIPS_KEY, 1), FIPS_RK1);
        check_eq("model_zero_rk10", ref_round_key(128'h0, 10), ZERO_RK10);

        rst = 1'b1;
        drive(128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b1);
        step();
        step();
        check_eq("reset_vld", vld_word(rk_vld), 128'h0);
        for (int s = 0; s <= NR; s++) check_eq("reset_key", stage_key(s), 128'h0);
        rst = 1'b0;
        idle(1);

        single_key("fips", FIPS_KEY, FIPS_RK1, FIPS_RK10);
        idle(NR + 1);
        single_key("zero", 128'h0, ZERO_RK1, ZERO_RK10);
        idle(NR + 1);

        // Bubble: valid, hole, valid.
        drive(FIPS_KEY, 1'b1);
        step();
        drive(128'hffff0000ffff0000ffff0000ffff0000, 1'b0);
        step();
        drive(128'h0, 1'b1);
        step();
        drive(128'h0, 1'b0);
        for (int i = 0; i < NR - 2; i++) step();
        check_eq("bubble_v0", vld_word(rk_vld), vld_word(11'b101_0000_0000));
        check_eq("bubble_k0", stage_key(NR), FIPS_RK10);
        step();
        check_eq("bubble_v1", vld_word({10'b0, rk_vld[NR]}), 128'h0);
        step();
        check_eq("bubble_v2", vld_word({10'b0, rk_vld[NR]}), 128'h1);
        check_eq("bubble_k2", stage_key(NR), ZERO_RK10);
        idle(NR + 1);

        // Streaming: 100 back-to-back keys, checked in order at RK10.
        for (int cyc = 0; cyc < 100 + NR; cyc++) begin
            if (cyc < 100) begin
                k = {$urandom(), $urandom(), $urandom(), $urandom()};
                drive(k, 1'b1);
                exp_q.push_back(ref_round_key(k, NR));
            end else begin
                drive(128'h0, 1'b0);
            end
            step();
            if (cyc >= NR) begin
                check_eq("stream_vld10", vld_word({10'b0, rk_vld[NR]}), 128'h1);
                check_eq("stream_rk10", stage_key(NR), exp_q.pop_front());
            end
            if (cyc >= NR && cyc < 100) begin
                check_eq("stream_vld_all", vld_word(rk_vld), vld_word('1));
            end
        end
        check_eq("stream_drained", 128'(exp_q.size()), 128'h0);
        idle(NR + 1);

        // Reset with five keys in flight.
        for (int i = 0; i < 5; i++) begin
            drive({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
            step();
        end
        check_eq("midrst_pre_vld", vld_word(rk_vld), vld_word(11'b000_0001_1111));
        rst = 1'b1;
        step();
        check_eq("midrst_vld", vld_word(rk_vld), 128'h0);
        for (int s = 0; s <= NR; s++) check_eq("midrst_key", stage_key(s), 128'h0);
        rst = 1'b0;
        single_key("post_rst", FIPS_KEY, FIPS_RK1, FIPS_RK10);
        idle(NR + 1);

        // Reset wins over a simultaneous key.
        rst = 1'b1;
        drive(FIPS_KEY, 1'b1);
        step();
        rst = 1'b0;
        drive(128'h0, 1'b0);
        for (int i = 0; i <= NR + 1; i++) begin
            check_eq("rst_prec_vld", vld_word(rk_vld), 128'h0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
